// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a 74LS253-style 4:1 selector.
// Grants one requester at a time. Each tenure is capped at HOLD_CYCLES
// cycles while others wait. A one-cycle disabled gap separates owners, so
// the tri-state output never changes source while it is enabled.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel_a,
    output logic       sel_b,
    output logic       en_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [1:0] owner;
    logic [1:0] last;
    logic [7:0] cnt;

    logic [1:0] win;
    logic [1:0] cand;
    logic       found;
    logic       others;

    // Rotating-priority pick: search last+1, last+2, last+3, then last itself
    always_comb begin
        win   = last;
        cand  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Any requester other than the current owner is waiting
    always_comb begin
        others = |(req & ~(4'b0001 << owner));
    end

    // Arbitration FSM with registered mux controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
            last  <= 2'd3;
            cnt   <= '0;
            gnt   <= '0;
            sel_a <= 1'b0;
            sel_b <= 1'b0;
            en_n  <= 1'b1;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (found) begin
                        state <= GRANT;
                        owner <= win;
                        last  <= win;
                        cnt   <= '0;
                        gnt   <= 4'b0001 << win;
                        sel_a <= win[0];
                        sel_b <= win[1];
                        en_n  <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        en_n  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[owner] || (cnt == HOLD_MAX && others)) begin
                        state <= GAP;
                        gnt   <= '0;
                        en_n  <= 1'b1;
                        busy  <= 1'b1;
                    end else if (cnt != HOLD_MAX) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    en_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed scenarios plus random traffic,
// checked against a tenure-level reference model.
module tb_mux4_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel_a, sel_b, en_n, busy;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 = no owner, 1 = owner holds grant, 2 = gap
    int m_mode, m_owner, m_last, m_sel, m_ten;

    mux4_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel_a(sel_a),
        .sel_b(sel_b),
        .en_n (en_n),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int l, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(l + k) % 4]) return (l + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r_rst, input logic [3:0] r);
        int p;
        if (r_rst) begin
            m_mode = 0; m_owner = 0; m_last = 3; m_sel = 0; m_ten = 0;
        end else if (m_mode == 1) begin
            if (!r[m_owner]) m_mode = 2;
            else if (m_ten >= HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) m_mode = 2;
            else m_ten++;
        end else begin
            p = pick(m_last, r);
            if (p >= 0) begin
                m_mode = 1; m_owner = p; m_last = p; m_sel = p; m_ten = 1;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        eg = (m_mode == 1) ? 4'(1 << m_owner) : 4'b0000;
        check({tag, ".gnt"},  {4'b0, gnt}, {4'b0, eg});
        check({tag, ".en_n"}, {7'b0, en_n}, {7'b0, (m_mode != 1)});
        check({tag, ".sel"},  {6'b0, sel_b, sel_a}, 8'(m_sel));
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, (m_mode != 0)});
    endtask

    // One clock: apply inputs, advance the model, sample 1 time unit after the edge
    task automatic step(input logic r_rst, input logic [3:0] r, input string tag);
        rst = r_rst;
        req = r;
        @(posedge clk);
        model_update(r_rst, r);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        m_mode = 0; m_owner = 0; m_last = 3; m_sel = 0; m_ten = 0;

        // Reset then idle
        step(1, 4'b0000, "rst0");
        step(1, 4'b0000, "rst1");
        check("rst_gnt", {4'b0, gnt}, 8'h00);
        check("rst_en_n", {7'b0, en_n}, 8'h01);
        for (int i = 0; i < 4; i++) step(0, 4'b0000, "idle");
        check("idle_busy", {7'b0, busy}, 8'h00);

        // Single requester on channel 2, held 20 cycles without preemption
        step(0, 4'b0100, "single");
        check("single_gnt", {4'b0, gnt}, 8'h04);
        check("single_sel", {6'b0, sel_b, sel_a}, 8'h02);
        for (int i = 0; i < 20; i++) step(0, 4'b0100, "single_hold");
        check("single_held", {4'b0, gnt}, 8'h04);
        step(0, 4'b0000, "single_gap");
        check("single_gap_en_n", {7'b0, en_n}, 8'h01);
        check("single_gap_busy", {7'b0, busy}, 8'h01);
        step(0, 4'b0000, "single_idle");
        check("single_idle_busy", {7'b0, busy}, 8'h00);

        // Full contention from reset: order 0,1,2,3,0, 4-cycle tenures, 1-cycle gaps
        step(1, 4'b0000, "fc_rst");
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < HOLD; c++) begin
                step(0, 4'b1111, "fc_ten");
                check("fc_owner", {4'b0, gnt}, 8'(1 << (t % 4)));
                check("fc_sel", {6'b0, sel_b, sel_a}, 8'(t % 4));
            end
            step(0, 4'b1111, "fc_gap");
            check("fc_gap_en_n", {7'b0, en_n}, 8'h01);
        end

        // Early release by owner 1 while channel 3 waits
        step(1, 4'b0000, "er_rst");
        step(0, 4'b0010, "er_g1");
        check("er_gnt1", {4'b0, gnt}, 8'h02);
        step(0, 4'b1010, "er_c2");
        step(0, 4'b1000, "er_gap");
        check("er_gap_gnt", {4'b0, gnt}, 8'h00);
        step(0, 4'b1000, "er_g3");
        check("er_gnt3", {4'b0, gnt}, 8'h08);
        check("er_sel3", {6'b0, sel_b, sel_a}, 8'h03);

        // Rotation: last=2, req=0101 -> channel 0; then channel 0 alone is re-granted
        step(1, 4'b0000, "rot_rst");
        step(0, 4'b0100, "rot_g2");
        step(0, 4'b0000, "rot_gap");
        step(0, 4'b0101, "rot_win");
        check("rot_gnt0", {4'b0, gnt}, 8'h01);
        step(0, 4'b0000, "rot_gap2");
        step(0, 4'b0001, "rot_regrant");
        check("rot_regnt0", {4'b0, gnt}, 8'h01);

        // Reset during the second cycle of a tenure
        step(0, 4'b0000, "mr_gap");
        step(0, 4'b0000, "mr_idle");
        step(0, 4'b0010, "mr_g1");
        step(1, 4'b0010, "mr_rst");
        check("mr_gnt", {4'b0, gnt}, 8'h00);
        check("mr_sel", {6'b0, sel_b, sel_a}, 8'h00);
        check("mr_en_n", {7'b0, en_n}, 8'h01);
        step(0, 4'b1000, "mr_g3");
        check("mr_gnt3", {4'b0, gnt}, 8'h08);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
